// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_port_arbiter                                          |
// | Description : Shares one sram-like memory port between the instruction-  |
// |               fetch requester (i_*) and the data-access requester (d_*). |
// |               One outstanding transfer, sequenced IDLE -> ADDR -> DATA,  |
// |               with a watchdog that aborts a hung transfer.               |
// | Config      : ARB_RR_EN defined   -> round-robin on simultaneous requests|
// |               ARB_RR_EN undefined -> fixed priority, data beats inst     |
// | Ports       : clk, rst            clock / synchronous active-high reset  |
// |               i_req/i_addr        inst read request and address          |
// |               i_addr_ok/i_data_ok/i_rdata   inst handshake and read data |
// |               d_req/d_wr/d_wen/d_addr/d_wdata  data request fields       |
// |               d_addr_ok/d_data_ok/d_rdata   data handshake and read data |
// |               m_req/m_wr/m_wen/m_addr/m_wdata  memory-side request       |
// |               m_addr_ok/m_data_ok/m_rdata      memory-side responses     |
// |               owner               current or last grant (1 = data)       |
// |               timeout             sticky watchdog-abort flag             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module sram_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [3:0]        d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [3:0]        m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              owner,
  output logic              timeout
);

  localparam logic [1:0] cStIdle = 2'd0;
  localparam logic [1:0] cStAddr = 2'd1;
  localparam logic [1:0] cStData = 2'd2;

  localparam int             cCntW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [cCntW-1:0] cTimeout = cCntW'(TIMEOUT_CYC);
  localparam bit             cWdEn    = (TIMEOUT_CYC != 0);

  logic [1:0]        rState;
  logic [1:0]        wNextState;
  logic              rOwner;
  logic              rWr;
  logic [3:0]        rWen;
  logic [ADDR_W-1:0] rAddr;
  logic [DATA_W-1:0] rWdata;
  logic [cCntW-1:0]  rWdCnt;
  logic              rTimeout;

  logic wGrantI;
  logic wGrantD;
  logic wBusy;
  logic wAbort;
  logic wDone;
  logic wFinish;

  // ---------------------------------------------------------------- arbiter
`ifdef ARB_RR_EN
  logic rRrPtr;  // 1: data wins the next tie, 0: inst wins

  always_comb begin
    wGrantI = 1'b0;
    wGrantD = 1'b0;
    if (rState == cStIdle) begin
      if (i_req && d_req) begin
        wGrantD = rRrPtr;
        wGrantI = ~rRrPtr;
      end else begin
        wGrantD = d_req;
        wGrantI = i_req;
      end
    end
  end

  // Pointer always favours whoever did not get the last grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rRrPtr <= 1'b1;
    end else if (wGrantI || wGrantD) begin
      rRrPtr <= wGrantI;
    end
  end
`else
  // Data wins: its instruction is older (already in MEM).
  always_comb begin
    wGrantD = (rState == cStIdle) && d_req;
    wGrantI = (rState == cStIdle) && i_req && !d_req;
  end
`endif

  // --------------------------------------------------------------- watchdog
  // Abort has priority over a memory response arriving in the same cycle.
  always_comb begin
    wBusy   = (rState == cStAddr) || (rState == cStData);
    wAbort  = cWdEn && wBusy && (rWdCnt == cTimeout);
    wDone   = !wAbort && (((rState == cStAddr) && m_addr_ok && m_data_ok) ||
                          ((rState == cStData) && m_data_ok));
    wFinish = wDone || wAbort;
  end

  // ------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rState <= cStIdle;
    end else begin
      rState <= wNextState;
    end
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    wNextState = rState;
    case (rState)
      cStIdle: begin
        if (wGrantI || wGrantD) wNextState = cStAddr;
      end
      cStAddr: begin
        if (wAbort || (m_addr_ok && m_data_ok)) wNextState = cStIdle;
        else if (m_addr_ok)                     wNextState = cStData;
      end
      cStData: begin
        if (wAbort || m_data_ok) wNextState = cStIdle;
      end
      default: wNextState = cStIdle;
    endcase
  end

  // -------------------------------------------- transfer fields / watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      rOwner   <= 1'b0;
      rWr      <= 1'b0;
      rWen     <= 4'd0;
      rAddr    <= '0;
      rWdata   <= '0;
      rWdCnt   <= '0;
      rTimeout <= 1'b0;
    end else begin
      if (wGrantI || wGrantD) begin
        rOwner <= wGrantD;
        rWr    <= wGrantD && d_wr;
        rWen   <= wGrantD ? d_wen : 4'd0;
        rAddr  <= wGrantD ? d_addr : i_addr;
        rWdata <= wGrantD ? d_wdata : '0;
        rWdCnt <= '0;
      end else if (cWdEn && wBusy) begin
        rWdCnt <= rWdCnt + 1'b1;
      end
      if (wAbort) rTimeout <= 1'b1;
    end
  end

  // ----------------------------------------------------------------- outputs
  always_comb begin
    i_addr_ok = wGrantI;
    d_addr_ok = wGrantD;
    m_req     = (rState == cStAddr) && !wAbort;
    i_data_ok = wFinish && !rOwner;
    d_data_ok = wFinish && rOwner;
    i_rdata   = (wDone && !rOwner) ? m_rdata : '0;
    d_rdata   = (wDone && rOwner) ? m_rdata : '0;
    m_wr      = rWr;
    m_wen     = rWen;
    m_addr    = rAddr;
    m_wdata   = rWdata;
    owner     = rOwner;
    timeout   = rTimeout;
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sram_port_arbiter                                       |
// | Description : Self-checking bench for sram_port_arbiter: directed cases  |
// |               followed by randomized transfers against a transfer-level  |
// |               reference model (grant choice, latency, watchdog abort).   |
// | Config      : honours ARB_RR_EN the same way as the design               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_sram_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_addr_ok, i_data_ok;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_wr, d_addr_ok, d_data_ok;
  logic [3:0]    d_wen;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_wr, m_addr_ok, m_data_ok;
  logic [3:0]    m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          owner, timeout;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .owner(owner), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: pending requests and their fields, last grant, sticky flag.
  bit          iPend, dPend;
  logic [31:0] iAddrQ, dAddrQ, dWdataQ;
  logic        dWrQ;
  logic [3:0]  dWenQ;
  logic        lastOwner;
  logic        expTimeout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveReqs();
    i_req   = iPend;
    i_addr  = iAddrQ;
    d_req   = dPend;
    d_wr    = dWrQ;
    d_wen   = dWenQ;
    d_addr  = dAddrQ;
    d_wdata = dWdataQ;
  endtask

  // One complete transfer: memory gives addr_ok aDly cycles after m_req first
  // rises and data_ok dDly cycles after that (dDly=0: same cycle).
  task automatic runTransfer(input int aDly, input int dDly, input logic [31:0] rd);
    logic        grantD, abortExp, expReq, expDone;
    int          endCyc;
    logic [31:0] eAddr;
    logic        eWr;
    logic [3:0]  eWen;
    logic [31:0] eWdata;
`ifdef ARB_RR_EN
    grantD = (iPend && dPend) ? ~lastOwner : dPend;
`else
    grantD = dPend;
`endif
    eAddr  = grantD ? dAddrQ : iAddrQ;
    eWr    = grantD ? dWrQ : 1'b0;
    eWen   = grantD ? dWenQ : 4'd0;
    eWdata = dWdataQ;
    if (1 + aDly + dDly <= TO) begin
      endCyc = 1 + aDly + dDly; abortExp = 1'b0;
    end else begin
      endCyc = TO + 1;          abortExp = 1'b1;
    end
    // grant cycle
    tick();
    driveReqs();
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = $urandom;
    #1;
    check("i_addr_ok@grant", i_addr_ok, !grantD);
    check("d_addr_ok@grant", d_addr_ok, grantD);
    check("m_req@grant", m_req, 0);
    check("timeout@grant", timeout, expTimeout);
    if (grantD) dPend = 0; else iPend = 0;
    lastOwner = grantD;
    for (int k = 1; k <= endCyc; k++) begin
      tick();
      driveReqs();
      m_addr_ok = (k == 1 + aDly);
      m_data_ok = (k == 1 + aDly + dDly);
      m_rdata   = (k == endCyc) ? rd : $urandom;
      #1;
      expReq  = (k <= 1 + aDly) && !(abortExp && k == endCyc);
      expDone = (k == endCyc);
      check("m_req", m_req, expReq);
      if (expReq) begin
        check("m_addr", m_addr, eAddr);
        check("m_wr", m_wr, eWr);
        check("m_wen", m_wen, eWen);
        if (grantD) check("m_wdata", m_wdata, eWdata);
      end
      check("owner", owner, grantD);
      check("addr_ok busy", {i_addr_ok, d_addr_ok}, 0);
      check("i_data_ok", i_data_ok, expDone && !grantD);
      check("d_data_ok", d_data_ok, expDone && grantD);
      check("i_rdata", i_rdata, (expDone && !grantD && !abortExp) ? rd : 32'd0);
      check("d_rdata", d_rdata, (expDone && grantD && !abortExp) ? rd : 32'd0);
    end
    if (abortExp) expTimeout = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    iPend = 0; dPend = 0; iAddrQ = 0; dAddrQ = 0; dWdataQ = 0; dWrQ = 0; dWenQ = 0;
    lastOwner = 0; expTimeout = 0;
    repeat (2) tick();
    check("reset m_req", m_req, 0);
    check("reset owner", owner, 0);
    check("reset timeout", timeout, 0);
    check("reset m_addr", m_addr, 0);
    check("reset oks", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
    rst = 1'b0;

    // Boot fetch: addr_ok at once, data one cycle later.
    iPend = 1; iAddrQ = 32'hBFC0_0000;
    runTransfer(0, 1, 32'h3C1D_0001);

    // Simultaneous requests, both held.
    iPend = 1; iAddrQ = 32'h0000_1000;
    dPend = 1; dAddrQ = 32'h0000_2000; dWrQ = 0; dWenQ = 0; dWdataQ = 0;
    runTransfer(0, 1, 32'hAAAA_0001);
    runTransfer(0, 1, 32'hAAAA_0002);

    // Both re-assert immediately for three transfers.
    for (int n = 0; n < 3; n++) begin
      iPend = 1; iAddrQ = 32'h0000_3000 + n;
      dPend = 1; dAddrQ = 32'h0000_4000 + n;
      runTransfer(0, 1, 32'hBBBB_0000 + n);
    end
    // drain whatever lost the last tie
    if (iPend || dPend) runTransfer(0, 1, 32'hBBBB_00FF);

    // Write with delayed m_addr_ok.
    dPend = 1; dWrQ = 1; dWenQ = 4'b0011; dAddrQ = 32'h8000_1000; dWdataQ = 32'h1234_5678;
    runTransfer(3, 1, 32'h0);

    // Memory never answers: watchdog abort, sticky flag.
    iPend = 1; iAddrQ = 32'h0000_5000;
    runTransfer(100, 100, 32'hDEAD_BEEF);
    tick();
    check("timeout sticky", timeout, 1);

    // Reset while in DATA.
    iPend = 1; iAddrQ = 32'h0000_6000;
    tick(); driveReqs(); m_addr_ok = 0; m_data_ok = 0; #1;
    check("rst case addr_ok", i_addr_ok, 1);
    iPend = 0;
    tick(); driveReqs(); m_addr_ok = 1; #1;
    check("rst case m_req", m_req, 1);
    tick(); m_addr_ok = 0; rst = 1; #1;
    check("rst case DATA m_req", m_req, 0);
    tick(); rst = 0; #1;
    check("after rst m_req", m_req, 0);
    check("after rst owner", owner, 0);
    check("after rst timeout", timeout, 0);
    check("after rst m_addr", m_addr, 0);
    check("after rst oks", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
    tick();
    tick(); m_data_ok = 1; m_rdata = 32'h5555_AAAA; #1;
    check("stale i_data_ok", i_data_ok, 0);
    check("stale d_data_ok", d_data_ok, 0);
    check("stale i_rdata", i_rdata, 0);
    lastOwner = 0; expTimeout = 0;

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if (!iPend && ($urandom_range(0, 1) == 1)) begin
        iPend = 1; iAddrQ = $urandom;
      end
      if (!dPend && ($urandom_range(0, 1) == 1 || !iPend)) begin
        dPend = 1; dAddrQ = $urandom; dWdataQ = $urandom;
        dWrQ = 1'($urandom_range(0, 1)); dWenQ = dWrQ ? 4'($urandom_range(1, 15)) : 4'd0;
      end
      runTransfer($urandom_range(0, 4), $urandom_range(0, 5), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
